// File: rtl/bar_pkg.sv
// -----------------------------------------------------------------------------
// bar_pkg
// Shared definitions for the LED-bar level decoder.
//   BAR_W          : width of the thermometer bar code
//   LVL_W          : width of the decoded bar level (0..7)
//   bar_state_e    : decoder FSM state (STABLE / SETTLING)
//   is_therm       : 1 when a code is a legal thermometer code (1<<n)-1, n=0..7
//   therm_to_level : number of lit segments of a legal code
// -----------------------------------------------------------------------------
package bar_pkg;

    localparam int BAR_W = 8;
    localparam int LVL_W = 3;

    typedef enum logic {
        ST_STABLE   = 1'b0,  // candidate equals the committed code
        ST_SETTLING = 1'b1   // candidate differs and is being timed
    } bar_state_e;

    // A thermometer code of the form 0..01..1 has no set bit above a clear bit,
    // so code & (code+1) is zero. The top bit must stay clear: 0xFF is not a
    // valid level because the bar only has seven steps.
    function automatic logic is_therm(input logic [BAR_W-1:0] code);
        logic [BAR_W-1:0] w_plus1;
        w_plus1 = code + {{(BAR_W-1){1'b0}}, 1'b1};
        return (code[BAR_W-1] == 1'b0) && ((code & w_plus1) == '0);
    endfunction

    // Population count of the lower seven bits; only meaningful for legal codes.
    function automatic logic [LVL_W-1:0] therm_to_level(input logic [BAR_W-1:0] code);
        logic [LVL_W-1:0] n;
        n = '0;
        for (int i = 0; i < BAR_W - 1; i++) begin
            if (code[i]) begin
                n = n + {{(LVL_W-1){1'b0}}, 1'b1};
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bar_sync.sv
// -----------------------------------------------------------------------------
// bar_sync
// Two-flop synchroniser for an asynchronous multi-bit input. No reset: the
// flops only move data across the clock boundary.
//   i_clk : sampling clock (rising edge)
//   i_d   : asynchronous input bus
//   o_q   : synchronised output (second flop)
// -----------------------------------------------------------------------------
module bar_sync #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk) begin
        r_s1 <= i_d;
        r_s2 <= r_s1;
    end

    assign o_q = r_s2;

endmodule

// File: rtl/bar_level_decoder.sv
// -----------------------------------------------------------------------------
// bar_level_decoder
// Debounces an asynchronous 8-bit thermometer LED-bar code and reports the
// committed bar level together with one-cycle change events.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset
//   bar_in      : asynchronous thermometer code
//   level       : committed bar level (held across illegal codes)
//   valid       : 1 while the last committed code was a legal thermometer code
//   inc         : pulse, level stepped up by exactly 1
//   dec         : pulse, level stepped down by exactly 1
//   clr         : pulse, level dropped to 0 from 2 or more
//   jump        : pulse, any other level change between legal codes
//   err         : pulse, an illegal code was committed
//   o_dbg_state : current FSM state, for observation only
//
// Handshake/timing: there is no handshake. A code is committed once the
// synchronised value has matched the candidate for STABLE_CYCLES consecutive
// checks; level/valid and the single event pulse update on the same edge,
// STABLE_CYCLES+3 edges after bar_in is first sampled with the new value.
// -----------------------------------------------------------------------------
module bar_level_decoder
    import bar_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BAR_W-1:0]  bar_in,
    output logic [LVL_W-1:0]  level,
    output logic              valid,
    output logic              inc,
    output logic              dec,
    output logic              clr,
    output logic              jump,
    output logic              err,
    output bar_state_e        o_dbg_state
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    logic [BAR_W-1:0] w_sync_q;
    logic [BAR_W-1:0] w_s2;
    logic [1:0]       r_flush;

    bar_sync #(
        .W (BAR_W)
    ) u_sync (
        .i_clk (clk),
        .i_d   (bar_in),
        .o_q   (w_sync_q)
    );

    // The synchroniser flops carry no reset, so a reset is made to look like
    // it cleared them: for the two cycles after reset the stale contents are
    // replaced by 0x00 until fresh post-reset samples have reached the output.
    assign w_s2 = (r_flush != 2'b00) ? '0 : w_sync_q;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    bar_state_e       r_state;
    logic [BAR_W-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [BAR_W-1:0] r_code;
    logic [LVL_W-1:0] r_level;
    logic             r_valid;
    logic             r_inc;
    logic             r_dec;
    logic             r_clr;
    logic             r_jump;
    logic             r_err;

    // -------------------------------------------------------------------------
    // Event classification of the candidate against the held level
    // -------------------------------------------------------------------------
    logic             w_cand_legal;
    logic [LVL_W-1:0] w_new_level;
    logic [LVL_W:0]   w_new_ext;
    logic [LVL_W:0]   w_old_ext;
    logic             w_ev_inc;
    logic             w_ev_dec;
    logic             w_ev_clr;
    logic             w_ev_jump;
    logic             w_match;
    logic             w_commit;

    always_comb begin
        w_cand_legal = is_therm(r_cand);
        w_new_level  = therm_to_level(r_cand);
        // One extra bit so level 7 + 1 cannot wrap to 0 in the comparisons.
        w_new_ext    = {1'b0, w_new_level};
        w_old_ext    = {1'b0, r_level};

        w_ev_inc  = 1'b0;
        w_ev_dec  = 1'b0;
        w_ev_clr  = 1'b0;
        w_ev_jump = 1'b0;
        // Priority order inc > dec > clr > jump; 1 -> 0 therefore reports dec.
        if (w_new_ext == w_old_ext + {{LVL_W{1'b0}}, 1'b1}) begin
            w_ev_inc = 1'b1;
        end else if (w_old_ext == w_new_ext + {{LVL_W{1'b0}}, 1'b1}) begin
            w_ev_dec = 1'b1;
        end else if ((w_new_level == '0) && (r_level >= LVL_W'(2))) begin
            w_ev_clr = 1'b1;
        end else if (w_new_level != r_level) begin
            w_ev_jump = 1'b1;
        end

        w_match  = (w_s2 == r_cand);
        w_commit = (r_state == ST_SETTLING) && w_match && (r_cnt == CNT_MAX);
    end

    // -------------------------------------------------------------------------
    // Candidate tracking, FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush <= 2'b11;
            r_state <= ST_STABLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_level <= '0;
            r_valid <= 1'b1;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_clr   <= 1'b0;
            r_jump  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_flush <= {r_flush[0], 1'b0};

            // Event outputs are single-cycle pulses.
            r_inc  <= 1'b0;
            r_dec  <= 1'b0;
            r_clr  <= 1'b0;
            r_jump <= 1'b0;
            r_err  <= 1'b0;

            // Any change of the synchronised code restarts the stability window.
            if (!w_match) begin
                r_cand <= w_s2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (r_state)
                ST_STABLE: begin
                    // Here candidate == committed code, so a mismatch is new.
                    if (!w_match) begin
                        r_state <= ST_SETTLING;
                    end
                end

                ST_SETTLING: begin
                    if (!w_match) begin
                        // A glitch that falls back to the committed code ends
                        // the settle without any commit.
                        if (w_s2 == r_code) begin
                            r_state <= ST_STABLE;
                        end
                    end else if (w_commit) begin
                        r_state <= ST_STABLE;
                        r_code  <= r_cand;
                        if (w_cand_legal) begin
                            r_valid <= 1'b1;
                            r_level <= w_new_level;
                            r_inc   <= w_ev_inc;
                            r_dec   <= w_ev_dec;
                            r_clr   <= w_ev_clr;
                            r_jump  <= w_ev_jump;
                        end else begin
                            // Illegal code: level is held, only err fires.
                            r_valid <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_STABLE;
                end
            endcase
        end
    end

    assign level       = r_level;
    assign valid       = r_valid;
    assign inc         = r_inc;
    assign dec         = r_dec;
    assign clr         = r_clr;
    assign jump        = r_jump;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bar_level_decoder.sv
// -----------------------------------------------------------------------------
// tb_bar_level_decoder
// Directed scenarios followed by randomized bar codes. The reference model
// works on the sampled bar_in history: a value that has been sampled on
// STABLE_CYCLES+1 consecutive edges is committed two edges later, if it
// differs from the currently committed code.
// -----------------------------------------------------------------------------
module tb_bar_level_decoder;
    import bar_pkg::*;

    localparam int S       = 4;
    localparam int RUN_CAP = 1000;

    // ---------------------------------------------------------------- clock/reset
    logic             clk = 1'b0;
    logic             rst;
    logic [BAR_W-1:0] bar_in;
    logic [LVL_W-1:0] level;
    logic             valid;
    logic             inc;
    logic             dec;
    logic             clr;
    logic             jump;
    logic             err;
    bar_state_e       dbg_state;

    always #5 clk = ~clk;

    bar_level_decoder #(
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bar_in      (bar_in),
        .level       (level),
        .valid       (valid),
        .inc         (inc),
        .dec         (dec),
        .clr         (clr),
        .jump        (jump),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------------------------------------------------------- model
    int         m_code;
    int         m_level;
    int         m_valid;
    logic [4:0] m_pulse;      // {inc, dec, clr, jump, err}
    int         run_val;
    int         run_len;
    logic       p0_ok, p1_ok;
    int         p0_v, p1_v;

    task model_commit(input int v);
        int legal;
        int nl;
        legal = 0;
        nl    = 0;
        for (int n = 0; n < 8; n++) begin
            if (v == (1 << n) - 1) begin
                legal = 1;
                nl    = n;
            end
        end
        m_code = v;
        if (legal == 1) begin
            if (nl == m_level + 1)                  m_pulse = 5'b10000;
            else if (nl == m_level - 1)             m_pulse = 5'b01000;
            else if (nl == 0 && m_level >= 2)       m_pulse = 5'b00100;
            else if (nl != m_level)                 m_pulse = 5'b00010;
            m_level = nl;
            m_valid = 1;
        end else begin
            m_valid = 0;
            m_pulse = 5'b00001;
        end
    endtask

    task model_edge;
        m_pulse = 5'b00000;
        if (rst) begin
            m_code  = 0;
            m_level = 0;
            m_valid = 1;
            run_val = 0;
            run_len = RUN_CAP;
            p0_ok   = 1'b0;
            p1_ok   = 1'b0;
        end else begin
            if (p1_ok && p1_v != m_code) model_commit(p1_v);
            p1_ok = p0_ok;
            p1_v  = p0_v;
            if (int'(bar_in) == run_val) begin
                if (run_len < RUN_CAP) run_len++;
            end else begin
                run_val = int'(bar_in);
                run_len = 1;
            end
            p0_ok = (run_len == S + 1);
            p0_v  = run_val;
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    int cnt_inc, cnt_dec, cnt_clr, cnt_jump, cnt_err;

    task clear_counts;
        cnt_inc  = 0;
        cnt_dec  = 0;
        cnt_clr  = 0;
        cnt_jump = 0;
        cnt_err  = 0;
    endtask

    task expect_eq(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task tick(input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        @(posedge clk);
        model_edge();
        #1;
        obs = {level, valid, inc, dec, clr, jump, err};
        exp = {m_level[LVL_W-1:0], m_valid[0], m_pulse};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed lvl/vld/pulses %b expected %b", tag, obs, exp);
        end
        cnt_inc  += int'(inc);
        cnt_dec  += int'(dec);
        cnt_clr  += int'(clr);
        cnt_jump += int'(jump);
        cnt_err  += int'(err);
    endtask

    // ---------------------------------------------------------------- driver tasks
    task hold(input logic [BAR_W-1:0] v, input int n, input string tag);
        bar_in = v;
        repeat (n) tick(tag);
    endtask

    // Holds v for n edges and reports the first edge (1-based) with any pulse.
    task watch(input logic [BAR_W-1:0] v, input int n, input string tag, output int first_evt);
        first_evt = 0;
        bar_in = v;
        for (int i = 1; i <= n; i++) begin
            tick(tag);
            if (first_evt == 0 && (inc | dec | clr | jump | err)) first_evt = i;
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int first_evt;
        int nrand;
        logic [BAR_W-1:0] v;

        rst    = 1'b1;
        bar_in = '0;
        clear_counts();
        tick("reset");
        tick("reset");
        expect_eq("reset_level", int'(level), 0);
        expect_eq("reset_valid", int'(valid), 1);
        rst = 1'b0;
        hold(8'h00, 4, "idle");

        // 0x00 -> 0x01: inc on the 7th edge
        clear_counts();
        watch(8'h01, 10, "up1", first_evt);
        expect_eq("up1_edge", first_evt, S + 3);
        expect_eq("up1_inc", cnt_inc, 1);
        expect_eq("up1_level", int'(level), 1);
        expect_eq("up1_valid", int'(valid), 1);

        // level 3 -> 0x03 dec -> 0x00 clr
        hold(8'h07, 10, "to3");
        clear_counts();
        hold(8'h03, 10, "dec2");
        expect_eq("dec2_dec", cnt_dec, 1);
        expect_eq("dec2_level", int'(level), 2);
        clear_counts();
        hold(8'h00, 10, "clr0");
        expect_eq("clr0_clr", cnt_clr, 1);
        expect_eq("clr0_dec", cnt_dec, 0);
        expect_eq("clr0_level", int'(level), 0);

        // level 1 -> 0x7F jump -> 0x3F dec
        hold(8'h01, 10, "to1");
        clear_counts();
        hold(8'h7F, 10, "jump7");
        expect_eq("jump7_jump", cnt_jump, 1);
        expect_eq("jump7_level", int'(level), 7);
        clear_counts();
        hold(8'h3F, 10, "dec6");
        expect_eq("dec6_dec", cnt_dec, 1);
        expect_eq("dec6_level", int'(level), 6);

        // 1 -> 0 reports dec, not clr
        hold(8'h01, 10, "to1b");
        clear_counts();
        hold(8'h00, 10, "one_to_zero");
        expect_eq("one_to_zero_dec", cnt_dec, 1);
        expect_eq("one_to_zero_clr", cnt_clr, 0);

        // 3-cycle glitch at level 2
        hold(8'h03, 10, "to2");
        clear_counts();
        hold(8'h0F, 3, "glitch");
        hold(8'h03, 10, "glitch_back");
        expect_eq("glitch_pulses", cnt_inc + cnt_dec + cnt_clr + cnt_jump + cnt_err, 0);
        expect_eq("glitch_level", int'(level), 2);

        // illegal 0x05: err once, level held; then 0x07 computed vs held level
        clear_counts();
        hold(8'h05, 20, "illegal");
        expect_eq("illegal_err", cnt_err, 1);
        expect_eq("illegal_valid", int'(valid), 0);
        expect_eq("illegal_level", int'(level), 2);
        clear_counts();
        hold(8'h07, 10, "recover");
        expect_eq("recover_valid", int'(valid), 1);
        expect_eq("recover_inc", cnt_inc, 1);
        expect_eq("recover_level", int'(level), 3);

        // two different illegal codes in a row, then 0xFF
        clear_counts();
        hold(8'h05, 10, "ill_a");
        hold(8'h09, 10, "ill_b");
        hold(8'hFF, 10, "ill_ff");
        expect_eq("ill_err_count", cnt_err, 3);
        expect_eq("ill_level", int'(level), 3);

        // reset mid-SETTLING toward 0x0F
        hold(8'h00, 10, "pre_rst");
        clear_counts();
        hold(8'h0F, 5, "settle");
        rst = 1'b1;
        tick("mid_rst");
        rst = 1'b0;
        expect_eq("mid_rst_pulses", cnt_inc + cnt_dec + cnt_clr + cnt_jump + cnt_err, 0);
        expect_eq("mid_rst_level", int'(level), 0);
        expect_eq("mid_rst_valid", int'(valid), 1);
        watch(8'h0F, 10, "post_rst", first_evt);
        expect_eq("post_rst_edge", first_evt, S + 3);
        expect_eq("post_rst_jump", cnt_jump, 1);
        expect_eq("post_rst_level", int'(level), 4);

        // randomized codes, hold lengths and occasional resets
        nrand = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) tick("rand_rst");
                rst = 1'b0;
            end
            if ($urandom_range(0, 9) < 7) begin
                v = BAR_W'((1 << $urandom_range(0, 7)) - 1);
            end else begin
                v = BAR_W'($urandom_range(0, 255));
            end
            hold(v, $urandom_range(1, 9), "rand");
            nrand++;
        end
        expect_eq("rand_steps", nrand, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
